// File: rtl/parity_stream.sv
// Streaming frame-parity checker: XORs every beat of a frame and reports parity, mismatch and beat count.
// Define PARITY_STREAM_ERRCNT_EN to add the saturating err_cnt output.
module parity_stream #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  input  logic             s_par,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_par,
  output logic             m_err,
  output logic [15:0]      m_beats
`ifdef PARITY_STREAM_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        live;
  logic        acc;
  logic [15:0] count;
  logic [15:0] count_inc;
  logic        beat_ok;
  logic        beat_par;
  logic        frame_par;
  logic        result_ok;

  assign beat_ok   = s_valid && s_ready;
  assign beat_par  = ^s_data;
  assign frame_par = acc ^ beat_par ^ ODD;
  assign result_ok = m_valid && m_ready;
  // Beat count sticks at all-ones so very long frames never report a small count.
  assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

  // live holds s_ready low while in reset and for nothing else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (beat_ok && s_last) state_nxt = HOLD;
      HOLD:    if (m_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  assign s_ready = live && (state == ACCUM);
  assign m_valid = (state == HOLD);

  // Running parity and count are cleared when the result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= 1'b0;
      count <= 16'd0;
    end else if (result_ok) begin
      acc   <= 1'b0;
      count <= 16'd0;
    end else if (beat_ok && !s_last) begin
      acc   <= acc ^ beat_par;
      count <= count_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_par   <= 1'b0;
      m_err   <= 1'b0;
      m_beats <= 16'd0;
    end else if (beat_ok && s_last) begin
      m_par   <= frame_par;
      m_err   <= frame_par ^ s_par;
      m_beats <= count_inc;
    end
  end

`ifdef PARITY_STREAM_ERRCNT_EN
  // Counts consumed results that flagged a mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (result_ok && m_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_stream.sv
// Self-checking bench for parity_stream: an even and an odd instance driven in lockstep,
// checked against a frame model that counts ones per frame.
`timescale 1ns/1ps
module tb_parity_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_last = 1'b0;
  logic       s_par = 1'b0;
  logic       m_ready = 1'b0;

  logic        s_ready, m_valid, m_par, m_err;
  logic [15:0] m_beats;
  logic        o_s_ready, o_m_valid, o_m_par, o_m_err;
  logic [15:0] o_m_beats;
`ifdef PARITY_STREAM_ERRCNT_EN
  logic [7:0]  err_cnt, o_err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int mdl_ones = 0;
  int mdl_count = 0;
  int mdl_errcnt = 0;
  logic        exp_par, exp_err, exp_opar, exp_oerr;
  logic [15:0] exp_beats;

  always #5 clk = ~clk;

  parity_stream #(.WIDTH(8), .ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_par(s_par), .m_valid(m_valid), .m_ready(m_ready),
    .m_par(m_par), .m_err(m_err), .m_beats(m_beats)
`ifdef PARITY_STREAM_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  parity_stream #(.WIDTH(8), .ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(o_s_ready), .s_data(s_data),
    .s_last(s_last), .s_par(s_par), .m_valid(o_m_valid), .m_ready(m_ready),
    .m_par(o_m_par), .m_err(o_m_err), .m_beats(o_m_beats)
`ifdef PARITY_STREAM_ERRCNT_EN
    , .err_cnt(o_err_cnt)
`endif
  );

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_cycle();
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    s_last  = 1'($urandom);
    s_par   = 1'($urandom);
    @(negedge clk);
  endtask

  // Presents one beat at a negedge, waits for acceptance, and updates the frame model.
  task automatic drive_beat(input logic [7:0] d, input logic last, input logic par);
    int waited = 0;
    s_valid = 1'b1; s_data = d; s_last = last; s_par = par;
    while (s_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (s_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("[TB] FAIL accept_timeout: s_ready=%b required 1", s_ready);
    end else begin
      @(posedge clk);
      mdl_ones += $countones(d);
      mdl_count++;
      if (last) begin
        exp_par   = 1'(mdl_ones % 2);
        exp_err   = exp_par ^ par;
        exp_opar  = ~exp_par;
        exp_oerr  = exp_opar ^ par;
        exp_beats = (mdl_count > 65535) ? 16'hFFFF : 16'(mdl_count);
        mdl_ones  = 0;
        mdl_count = 0;
      end
      @(negedge clk);
    end
    s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom); s_par = 1'($urandom);
  endtask

  task automatic release_result();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    if (exp_err && mdl_errcnt < 255) mdl_errcnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1; s_par = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_s_ready: got %b need 0", s_ready); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_valid: got %b need 0", m_valid); end
    vectors++; if (m_par !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_par: got %b need 0", m_par); end
    vectors++; if (m_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_err: got %b need 0", m_err); end
    vectors++; if (m_beats !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_m_beats: got %h need 0000", m_beats); end
`ifdef PARITY_STREAM_ERRCNT_EN
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_err_cnt: got %h need 00", err_cnt); end
`endif
    s_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_before_edge: got %b need 0", s_ready); end
    @(negedge clk);
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ready_after_edge: got %b need 1", s_ready); end
  endtask

  task automatic test_basic();
    drive_beat(8'h01, 1'b0, 1'b0);
    drive_beat(8'h03, 1'b1, 1'b1);
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_latency: m_valid=%b need 1", m_valid); end
    vectors++; if (m_par !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_par: got %b need 1", m_par); end
    vectors++; if (m_err !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_err: got %b need 0", m_err); end
    vectors++; if (m_beats !== 16'd2) begin miscompares++; $display("[TB] FAIL basic_beats: got %0d need 2", m_beats); end
    release_result();
    vectors++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_release: s_ready=%b m_valid=%b need 1/0", s_ready, m_valid); end
  endtask

  task automatic test_single();
    drive_beat(8'hFF, 1'b1, 1'b1);
    vectors++; if (m_par !== 1'b0) begin miscompares++; $display("[TB] FAIL single_par: got %b need 0", m_par); end
    vectors++; if (m_err !== 1'b1) begin miscompares++; $display("[TB] FAIL single_err: got %b need 1", m_err); end
    vectors++; if (m_beats !== 16'd1) begin miscompares++; $display("[TB] FAIL single_beats: got %0d need 1", m_beats); end
    release_result();
`ifdef PARITY_STREAM_ERRCNT_EN
    vectors++; if (err_cnt !== 8'(mdl_errcnt)) begin miscompares++; $display("[TB] FAIL single_err_cnt: got %0d need %0d", err_cnt, mdl_errcnt); end
`endif
  endtask

  task automatic test_odd();
    drive_beat(8'h00, 1'b1, 1'b1);
    vectors++; if (o_m_par !== 1'b1) begin miscompares++; $display("[TB] FAIL odd_par: got %b need 1", o_m_par); end
    vectors++; if (o_m_err !== 1'b0) begin miscompares++; $display("[TB] FAIL odd_err: got %b need 0", o_m_err); end
    release_result();
  endtask

  task automatic test_backpressure();
    drive_beat(8'h5A, 1'b1, 1'b0);
    s_valid = 1'b1; s_data = 8'h0F; s_last = 1'b1; s_par = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready: got %b need 0", s_ready); end
      vectors++;
      if (m_valid !== 1'b1 || m_par !== exp_par || m_err !== exp_err || m_beats !== exp_beats) begin
        miscompares++;
        $display("[TB] FAIL bp_stable: got v=%b p=%b e=%b n=%0d need 1/%b/%b/%0d", m_valid, m_par, m_err, m_beats, exp_par, exp_err, exp_beats);
      end
      @(negedge clk);
    end
    release_result();
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ready_rise: got %b need 1", s_ready); end
    @(negedge clk);
    s_valid = 1'b0;
    exp_par = 1'b0; exp_err = 1'b1; exp_beats = 16'd1;
    vectors++;
    if (m_valid !== 1'b1 || m_par !== exp_par || m_err !== exp_err || m_beats !== exp_beats) begin
      miscompares++;
      $display("[TB] FAIL bp_held_beat: got v=%b p=%b e=%b n=%0d need 1/0/1/1", m_valid, m_par, m_err, m_beats);
    end
    release_result();
    repeat (3) idle_cycle();
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_once: m_valid=%b need 0", m_valid); end
  endtask

  task automatic test_reset_midframe();
    drive_beat(8'h80, 1'b0, 1'b0);
    drive_beat(8'h80, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    vectors++; if (s_ready !== 1'b0 || m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset: s_ready=%b m_valid=%b need 0/0", s_ready, m_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_ones = 0; mdl_count = 0; mdl_errcnt = 0;
    @(negedge clk);
    drive_beat(8'h01, 1'b1, 1'b0);
    vectors++; if (m_par !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_par: got %b need 1", m_par); end
    vectors++; if (m_beats !== 16'd1) begin miscompares++; $display("[TB] FAIL mid_beats: got %0d need 1", m_beats); end
    release_result();
    drive_beat(8'h07, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_errcnt = 0;
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      vectors++; if (m_valid !== 1'b0 || m_par !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_reset: m_valid=%b m_par=%b need 0/0", m_valid, m_par); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) idle_cycle();
        drive_beat(8'($urandom), 1'(b == len - 1), 1'($urandom));
      end
      vectors++;
      if (m_valid !== 1'b1 || m_par !== exp_par || m_err !== exp_err || m_beats !== exp_beats) begin
        miscompares++;
        $display("[TB] FAIL rand_frame%0d: got v=%b p=%b e=%b n=%0d need 1/%b/%b/%0d", f, m_valid, m_par, m_err, m_beats, exp_par, exp_err, exp_beats);
      end
      vectors++;
      if (o_m_par !== exp_opar || o_m_err !== exp_oerr) begin
        miscompares++;
        $display("[TB] FAIL rand_odd%0d: got p=%b e=%b need %b/%b", f, o_m_par, o_m_err, exp_opar, exp_oerr);
      end
      repeat ($urandom_range(0, 3)) idle_cycle();
      release_result();
`ifdef PARITY_STREAM_ERRCNT_EN
      vectors++; if (err_cnt !== 8'(mdl_errcnt)) begin miscompares++; $display("[TB] FAIL rand_err_cnt%0d: got %0d need %0d", f, err_cnt, mdl_errcnt); end
`endif
    end
  endtask

  task automatic test_saturation();
    s_valid = 1'b1; s_data = 8'h01; s_last = 1'b0; s_par = 1'b0;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_ready: got %b need 1", s_ready); end
    repeat (69999) @(negedge clk);
    mdl_ones += 69999;
    mdl_count += 69999;
    drive_beat(8'h01, 1'b1, 1'b0);
    vectors++; if (m_beats !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_beats: got %h need ffff", m_beats); end
    vectors++; if (m_par !== exp_par || exp_par !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_par: got %b need 0", m_par); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_odd();
    test_backpressure();
    test_reset_midframe();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_stream.md
PARITY_STREAM -- requirements
Module: parity_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data beat width in bits (legal range 1..64).
REQ-002 SHALL have parameter ODD, default 0, meaning parity sense (0 = even, 1 = odd).
REQ-003 SHALL have port clk  input  1  the single clock; all flops rise on clk posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_valid  input  1  input beat valid.
REQ-006 SHALL have port s_ready  output  1  input beat accepted when s_valid and s_ready are both 1.
REQ-007 SHALL have port s_data  input  WIDTH  input beat data.
REQ-008 SHALL have port s_last  input  1  marks the final beat of a frame.
REQ-009 SHALL have port s_par  input  1  expected frame parity, sampled on the last beat only.
REQ-010 SHALL have port m_valid  output  1  frame result valid.
REQ-011 SHALL have port m_ready  input  1  result consumed when m_valid and m_ready are both 1.
REQ-012 SHALL have port m_par  output  1  computed frame parity.
REQ-013 SHALL have port m_err  output  1  mismatch flag, 1 when m_par != s_par.
REQ-014 SHALL have port m_beats  output  16  beat count of the frame, including the last beat.

Function
REQ-015 SHALL implement a two-state FSM: ACCUM (s_ready=1, m_valid=0) and HOLD (s_ready=0, m_valid=1).
REQ-016 In ACCUM, each accepted non-last beat SHALL update acc <= acc XOR (XOR-reduce s_data) and beat count <= count+1.
REQ-017 In ACCUM, an accepted last beat SHALL register m_par = acc ^ (^s_data) ^ ODD, m_err = m_par ^ s_par, m_beats = count+1, and move the FSM to HOLD.
REQ-018 Latency SHALL be one cycle: m_valid asserts on the clk edge that accepts the last beat.
REQ-019 In HOLD, m_par, m_err and m_beats SHALL remain stable, and no input beat SHALL be accepted.
REQ-020 In HOLD, the cycle with m_ready=1 SHALL clear acc and count and return the FSM to ACCUM; s_ready SHALL rise on the next cycle (no combinational m_ready to s_ready path).
REQ-021 A single-beat frame (s_last=1 on the first beat) SHALL produce m_beats=1.
REQ-022 The beat count SHALL saturate at 16'hFFFF and never wrap; the parity SHALL remain correct past saturation.
REQ-023 s_data, s_last and s_par SHALL be ignored when s_valid=0.
REQ-024 s_ready and m_valid SHALL be driven directly from FSM state.

Reset
REQ-025 While rst_n=0, the FSM SHALL be in ACCUM with acc=0 and count=0.
REQ-026 While rst_n=0, the outputs SHALL be s_ready=0, m_valid=0, m_par=0, m_err=0, m_beats=0.
REQ-027 s_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-028 A reset asserted mid-frame or in HOLD SHALL discard the partial frame or pending result, and no result for it SHALL ever appear.

Configuration
REQ-029 With macro PARITY_STREAM_ERRCNT_EN defined, the block SHALL add output port err_cnt (output, 8 bits): a count of results handshaken with m_err=1, saturating at 8'hFF, reset to 0.
REQ-030 Without PARITY_STREAM_ERRCNT_EN, the err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Even parity, WIDTH=8, ODD=0: beats 0x01, then 0x03 with s_last=1 and s_par=1 -> m_par=1, m_err=0, m_beats=2, m_valid one cycle after the last beat.
REQ-032 Single beat 0xFF with s_last=1 and s_par=1 -> m_par=0, m_err=1, m_beats=1; with the macro defined, err_cnt=1 after the handshake.
REQ-033 Backpressure: hold m_ready=0 for 3 cycles with s_valid=1 -> s_ready=0 and outputs stable throughout; on m_ready=1, s_ready=1 on the next cycle and the held beat is accepted exactly once.
REQ-034 ODD=1: single beat 0x00 with s_last=1 and s_par=1 -> m_par=1, m_err=0.
REQ-035 Reset mid-frame: after 2 beats of 0x80 assert rst_n=0, release, then send beat 0x01 with s_last=1 -> m_par=1, m_beats=1.
REQ-036 Saturation: 70000 beats of 0x01, the last with s_last=1 -> m_beats=0xFFFF and m_par=0 (70000 is even).
